bcd2bin_seq: RTL and testbench

- Sequential BCD-to-binary decoder: takes a packed multi-digit BCD value, such as the output of the cascaded BCD counters, and returns its binary equivalent.
- Processes one digit per clock, most significant first, using acc = acc*10 + digit.
- Uses a start/busy/done handshake so that counter and display paths can hand values to binary arithmetic logic.
- Flags any non-BCD digit (value above 9).

---
 rtl/bcd2bin_seq_if.sv | 36 +++
 rtl/bcd2bin_seq.sv | 104 ++++++++++
 tb/tb_bcd2bin_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_seq_if.sv
// bcd2bin_seq_if: bundles the start/busy/done conversion handshake.
//
// Handshake: the requester raises start with bcd_in stable. The converter
// samples start only while idle, and only on that accepting edge does it
// capture bcd_in. busy is high while digits are processed. done pulses for
// one cycle, and in that cycle bin_out/err hold the new result; they keep it
// until the next done pulse (or reset). start is ignored while busy or done.
//
// Signals:
//   start   - conversion request (master -> slave)
//   bcd_in  - packed BCD, most significant digit in the top nibble
//   busy    - digits being processed (slave -> master)
//   done    - one-cycle completion pulse
//   bin_out - binary result
//   err     - a digit above 9 was seen in the last conversion
interface bcd2bin_seq_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, err
  );
endinterface

// File: rtl/bcd2bin_seq.sv
// bcd2bin_seq: sequential BCD-to-binary decoder.
//
// Converts a packed DIGITS-digit BCD value to binary, one digit per clock,
// most significant first, with acc = acc*10 + digit. Any digit above 9 sets
// err and forces bin_out to 0 for that conversion.
//
// Ports:
//   clk       - system clock, rising edge active
//   reset     - asynchronous, active-high reset
//   bus       - slave side of bcd2bin_seq_if (start, bcd_in, busy, done,
//               bin_out, err)
//   dbg_state - current FSM state (0 IDLE, 1 CONV, 2 DONE) for observation
module bcd2bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  bcd2bin_seq_if.slave      bus,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SR_W  = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [SR_W-1:0]  sreg;
  logic [BIN_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             err_latch;

  // Current digit is always the top nibble; the register shifts left.
  logic [3:0]       digit;
  logic             digit_bad;
  logic [BIN_W-1:0] acc_next;
  logic             err_next;

  assign digit     = sreg[SR_W-1 -: 4];
  assign digit_bad = (digit > 4'd9);
  // acc*10 as two shifts and an add; wraps modulo 2^BIN_W by design.
  assign acc_next  = (acc << 3) + (acc << 1) + BIN_W'(digit);
  assign err_next  = err_latch | digit_bad;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sreg        <= '0;
      acc         <= '0;
      cnt         <= '0;
      err_latch   <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.bin_out <= '0;
      bus.err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sreg      <= bus.bcd_in;
            acc       <= '0;
            cnt       <= '0;
            err_latch <= 1'b0;
            bus.busy  <= 1'b1;
            state     <= CONV;
          end
        end

        CONV: begin
          acc       <= acc_next;
          sreg      <= sreg << 4;
          cnt       <= cnt + 1'b1;
          err_latch <= err_next;
          if (cnt == CNT_W'(DIGITS - 1)) begin
            // Last digit: publish, including this digit's validity.
            bus.bin_out <= err_next ? '0 : acc_next;
            bus.err     <= err_next;
            bus.done    <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= DONE;
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb_bcd2bin_seq: directed bench for bcd2bin_seq (DIGITS=3, BIN_W=10).
// Driver tasks issue conversions and push hand-computed results into exp_q;
// a monitor pops and compares on every done pulse and also checks busy
// duration, done width/spacing and that outputs hold between completions.
module tb_bcd2bin_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  bcd2bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected entries are {err, bin_out}.
  logic [BIN_W:0] exp_q[$];

  // ---------------- scoreboard / monitor ----------------
  int             cyc        = 0;
  int             busy_cnt   = 0;
  int             last_done  = -1;
  logic           prev_done  = 1'b0;
  logic           spacing_on = 1'b0;
  logic [BIN_W:0] held       = '0;

  always @(negedge clk) begin
    logic [BIN_W:0] e;
    cyc = cyc + 1;
    if (reset) begin
      busy_cnt  = 0;
      held      = '0;
      prev_done = 1'b0;
    end else begin
      if (bus.busy) busy_cnt = busy_cnt + 1;
      if (bus.done) begin
        total = total + 1;
        if (prev_done) begin
          bad = bad + 1;
          $display("FAIL done_width: done high two cycles at cycle %0d", cyc);
        end
        total = total + 1;
        if (busy_cnt != DIGITS || bus.busy) begin
          bad = bad + 1;
          $display("FAIL busy_len: busy cycles=%0d busy_now=%0b, required %0d and 0",
                   busy_cnt, bus.busy, DIGITS);
        end
        busy_cnt = 0;
        if (spacing_on && last_done >= 0) begin
          total = total + 1;
          if (cyc - last_done != DIGITS + 2) begin
            bad = bad + 1;
            $display("FAIL done_spacing: got %0d cycles, required %0d",
                     cyc - last_done, DIGITS + 2);
          end
        end
        last_done = cyc;
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_done: bin_out=%0d err=%0b with nothing expected",
                   bus.bin_out, bus.err);
        end else begin
          e = exp_q.pop_front();
          if ({bus.err, bus.bin_out} !== e) begin
            bad = bad + 1;
            $display("FAIL result: got bin_out=%0d err=%0b, required bin_out=%0d err=%0b",
                     bus.bin_out, bus.err, e[BIN_W-1:0], e[BIN_W]);
          end
          held = e;
        end
      end else begin
        total = total + 1;
        if ({bus.err, bus.bin_out} !== held) begin
          bad = bad + 1;
          $display("FAIL hold: got bin_out=%0d err=%0b, required bin_out=%0d err=%0b",
                   bus.bin_out, bus.err, held[BIN_W-1:0], held[BIN_W]);
        end
      end
      prev_done = bus.done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 20);
    if (!bus.done) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL timeout: no done within 20 cycles");
    end
  endtask

  task automatic convert(input logic [4*DIGITS-1:0] v, input int exp_bin,
                         input logic exp_err);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = v;
    exp_q.push_back({exp_err, BIN_W'(exp_bin)});
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
  endtask

  task automatic check_idle_outputs(input string name);
    total = total + 1;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bin_out !== '0 || bus.err !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL %s: busy=%0b done=%0b bin_out=%0d err=%0b, required all 0",
               name, bus.busy, bus.done, bus.bin_out, bus.err);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    reset      = 1'b1;
    #1;
    check_idle_outputs("reset_async");
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_held");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_idle_outputs("idle_no_start");

    // Single conversion.
    convert(12'h999, 999, 1'b0);
    repeat (3) @(negedge clk);

    // Back-to-back: each start in the first IDLE cycle after done.
    convert(12'h000, 0, 1'b0);
    convert(12'h105, 105, 1'b0);
    convert(12'h090, 90, 1'b0);

    // Invalid middle digit, then a clean conversion clears err.
    convert(12'h1A3, 0, 1'b1);
    convert(12'h042, 42, 1'b0);
    convert(12'hF00, 0, 1'b1);
    convert(12'h00C, 0, 1'b1);
    convert(12'h001, 1, 1'b0);

    // start held high: one conversion per IDLE visit, input changes after
    // acceptance are ignored.
    @(negedge clk);
    spacing_on = 1'b1;
    last_done  = -1;
    bus.start  = 1'b1;
    bus.bcd_in = 12'h250;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, BIN_W'(250)});
      @(negedge clk);
      bus.bcd_in = 12'h777;
      repeat (2) @(negedge clk);
      bus.bcd_in = 12'h250;
      wait_done();
      if (i == 2) bus.start = 1'b0;
      else @(negedge clk);
    end
    repeat (3) @(negedge clk);
    spacing_on = 1'b0;

    // Reset mid-conversion aborts with no done.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = 12'h999;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle_outputs("reset_abort");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_idle_outputs("after_abort");

    convert(12'h321, 321, 1'b0);
    repeat (3) @(negedge clk);

    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL leftover: %0d results never produced, required 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
